// File: rtl/adaptive_filter.sv
// Mode-switchable first-order filter: running-sum integrator (ctrl=1) or first difference (ctrl=0).
// Optional feature: define ADAPTIVE_FILTER_SAT_EN to saturate results instead of wrapping.
module adaptive_filter #(
  parameter int DATA_WIDTH = 14,
  parameter int FRAC_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  ctrl,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic [DATA_WIDTH-1:0] m_tdata
);

  localparam int WW = DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] x_prev_q, x_prev_d;

  logic [WW-1:0] x_ext, acc_ext, x_prev_ext;
  logic [WW-1:0] sum_wide, diff_wide;
  logic [DATA_WIDTH-1:0] sum_red, diff_red;

  // FRAC_WIDTH only documents the Q format; the binary point never moves.
  logic unused_frac;
  assign unused_frac = (FRAC_WIDTH < 0);

  function automatic logic [DATA_WIDTH-1:0] reduce(input logic [WW-1:0] r);
`ifdef ADAPTIVE_FILTER_SAT_EN
    logic [DATA_WIDTH-1:0] max_v;
    logic [DATA_WIDTH-1:0] min_v;
    max_v = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    min_v = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    // Overflow is visible as disagreement between the two top bits.
    if (r[WW-1] != r[WW-2]) begin
      reduce = r[WW-1] ? min_v : max_v;
    end else begin
      reduce = r[DATA_WIDTH-1:0];
    end
`else
    logic unused_msb;
    unused_msb = r[WW-1];
    reduce = r[DATA_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    x_ext      = {s_tdata[DATA_WIDTH-1], s_tdata};
    acc_ext    = {acc_q[DATA_WIDTH-1], acc_q};
    x_prev_ext = {x_prev_q[DATA_WIDTH-1], x_prev_q};
    sum_wide   = acc_ext + x_ext;
    diff_wide  = x_ext - x_prev_ext;
    sum_red    = reduce(sum_wide);
    diff_red   = reduce(diff_wide);
  end

  always_comb begin
    m_tdata_d = m_tdata_q;
    acc_d     = acc_q;
    x_prev_d  = s_tdata;
    if (ctrl) begin
      m_tdata_d = sum_red;
      acc_d     = sum_red;
    end else begin
      // acc is held at zero so a later switch to integrate starts fresh.
      m_tdata_d = diff_red;
      acc_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      m_tdata_q <= '0;
      acc_q     <= '0;
      x_prev_q  <= '0;
    end else begin
      m_tdata_q <= m_tdata_d;
      acc_q     <= acc_d;
      x_prev_q  <= x_prev_d;
    end
  end

  assign m_tdata = m_tdata_q;

endmodule

// File: tb/tb_adaptive_filter.sv
// Directed bench for adaptive_filter: reset, integrate, differentiate, overflow, mode switching.
module tb_adaptive_filter;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          srst;
  logic          ctrl;
  logic [DW-1:0] s_tdata;
  logic [DW-1:0] m_tdata;

  int n_tests = 0;
  int n_fail  = 0;

  adaptive_filter #(.DATA_WIDTH(DW), .FRAC_WIDTH(6)) dut (
    .clk    (clk),
    .srst   (srst),
    .ctrl   (ctrl),
    .s_tdata(s_tdata),
    .m_tdata(m_tdata)
  );

  always #5 clk = ~clk;

  // Apply one sample, then wait until just after the edge that consumes it.
  task automatic step(input logic r, input logic c, input int x);
    srst    = r;
    ctrl    = c;
    s_tdata = DW'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
  endtask

  task automatic test_reset();
    int xs[3] = '{1234, -777, 8191};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i[0], xs[i]);
      n_tests++;
      $display("[TB] reset cyc=%0d x=%0d y=%0d", i, xs[i], $signed(m_tdata));
      if (m_tdata !== DW'(0)) begin
        n_fail++;
        $display("FAIL reset_%0d: got %0d expected 0", i, $signed(m_tdata));
      end
    end
    step(1'b0, 1'b0, 0);
    n_tests++;
    $display("[TB] reset release x=0 y=%0d", $signed(m_tdata));
    if (m_tdata !== DW'(0)) begin
      n_fail++;
      $display("FAIL reset_release: got %0d expected 0", $signed(m_tdata));
    end
  endtask

  task automatic test_integrator();
    int ex[4] = '{64, 128, 192, 256};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0 == 1'b1, 1'b1, 64);
      n_tests++;
      $display("[TB] integ n=%0d x=64 y=%0d", i, $signed(m_tdata));
      if (m_tdata !== DW'(ex[i])) begin
        n_fail++;
        $display("FAIL integ_%0d: got %0d expected %0d", i, $signed(m_tdata), ex[i]);
      end
    end
  endtask

  task automatic test_differentiator();
    int xs[5] = '{0, 64, 128, 192, -64};
    int ex[5] = '{0, 64, 64, 64, -256};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, xs[i]);
      n_tests++;
      $display("[TB] diff n=%0d x=%0d y=%0d", i, xs[i], $signed(m_tdata));
      if (m_tdata !== DW'(ex[i])) begin
        n_fail++;
        $display("FAIL diff_%0d: got %0d expected %0d", i, $signed(m_tdata), ex[i]);
      end
    end
  endtask

  task automatic test_integ_overflow();
`ifdef ADAPTIVE_FILTER_SAT_EN
    int ex[2] = '{8191, 8191};
`else
    int ex[2] = '{8191, -2};
`endif
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 8191);
      n_tests++;
      $display("[TB] integ_ovf n=%0d x=8191 y=%0d", i, $signed(m_tdata));
      if (m_tdata !== DW'(ex[i])) begin
        n_fail++;
        $display("FAIL integ_ovf_%0d: got %0d expected %0d", i, $signed(m_tdata), ex[i]);
      end
    end
    // Saturated value must be what acc holds: adding -1 exposes it.
    step(1'b0, 1'b1, -1);
    n_tests++;
    $display("[TB] integ_ovf acc x=-1 y=%0d", $signed(m_tdata));
    if (m_tdata !== DW'(ex[1] - 1)) begin
      n_fail++;
      $display("FAIL integ_ovf_acc: got %0d expected %0d", $signed(m_tdata), ex[1] - 1);
    end
  endtask

  task automatic test_diff_overflow();
    int xs[2] = '{8191, -8192};
`ifdef ADAPTIVE_FILTER_SAT_EN
    int ex[2] = '{8191, -8192};
`else
    int ex[2] = '{8191, 1};
`endif
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, xs[i]);
      n_tests++;
      $display("[TB] diff_ovf n=%0d x=%0d y=%0d", i, xs[i], $signed(m_tdata));
      if (m_tdata !== DW'(ex[i])) begin
        n_fail++;
        $display("FAIL diff_ovf_%0d: got %0d expected %0d", i, $signed(m_tdata), ex[i]);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic cs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int   xs[7] = '{64, 64, 64, 64, 64, 64, -16};
    int   ex[7] = '{64, 128, 192, 256, 0, 64, 48};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, cs[i], xs[i]);
      n_tests++;
      $display("[TB] switch n=%0d ctrl=%0d x=%0d y=%0d", i, cs[i], xs[i], $signed(m_tdata));
      if (m_tdata !== DW'(ex[i])) begin
        n_fail++;
        $display("FAIL switch_%0d: got %0d expected %0d", i, $signed(m_tdata), ex[i]);
      end
    end
    // 1->0 uses the true previous sample (-16): 100 - (-16) = 116.
    step(1'b0, 1'b0, 100);
    n_tests++;
    $display("[TB] switch 1->0 x=100 y=%0d", $signed(m_tdata));
    if (m_tdata !== DW'(116)) begin
      n_fail++;
      $display("FAIL switch_1to0: got %0d expected 116", $signed(m_tdata));
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64);
    step(1'b1, 1'b1, 64);
    n_tests++;
    $display("[TB] mid_reset srst=1 y=%0d", $signed(m_tdata));
    if (m_tdata !== DW'(0)) begin
      n_fail++;
      $display("FAIL mid_reset: got %0d expected 0", $signed(m_tdata));
    end
    step(1'b0, 1'b1, 64);
    n_tests++;
    $display("[TB] mid_reset after x=64 y=%0d", $signed(m_tdata));
    if (m_tdata !== DW'(64)) begin
      n_fail++;
      $display("FAIL mid_reset_after: got %0d expected 64", $signed(m_tdata));
    end
    // x_prev must also have been cleared: differentiate right after a reset.
    step(1'b1, 1'b0, 500);
    step(1'b0, 1'b0, 30);
    n_tests++;
    $display("[TB] mid_reset diff x=30 y=%0d", $signed(m_tdata));
    if (m_tdata !== DW'(30)) begin
      n_fail++;
      $display("FAIL mid_reset_xprev: got %0d expected 30", $signed(m_tdata));
    end
  endtask

  initial begin
    srst    = 1'b1;
    ctrl    = 1'b0;
    s_tdata = '0;
    test_reset();
    test_integrator();
    test_differentiator();
    test_integ_overflow();
    test_diff_overflow();
    test_mode_switch();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
